// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch sequencer and its environment: PC register,
// instruction memory, decode handshake and execute redirect.
interface fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    pc;
  logic               pc_we;
  logic [PC_W-1:0]    pc_next;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  modport master (
    input  pc,
    output pc_we, pc_next,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    output pc,
    input  pc_we, pc_next,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests imem at the PC, hands the word to decode
// and steers the PC register (sequential increment or execute redirect).
module fetch_unit #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PC_W-1:0]    addr_r, addr_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic [PC_W-1:0]    instr_pc_r, instr_pc_s;
  logic               pc_we_s;
  logic [PC_W-1:0]    pc_next_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= {PC_W{1'b0}};
      instr_r    <= {INSTR_W{1'b0}};
      instr_pc_r <= {PC_W{1'b0}};
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
    end
  end

  // Next-state, capture and PC-update decisions
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    pc_we_s    = 1'b0;
    pc_next_s  = bus.pc;
    case (state_r)
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_we_s   = 1'b1;
          pc_next_s = bus.redirect_pc;
          addr_s    = bus.redirect_pc;
        end else begin
          addr_s    = addr_r;
        end
        state_s = REQ;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_we_s   = 1'b1;
          pc_next_s = bus.redirect_pc;
          // Without ack the old request must stay on the bus until it completes
          if (bus.imem_ack) begin
            addr_s  = bus.redirect_pc;
            state_s = REQ;
          end else begin
            state_s = FLUSH;
          end
        end else if (bus.imem_ack) begin
          instr_s    = bus.imem_rdata;
          instr_pc_s = bus.pc;
          pc_we_s    = 1'b1;
          pc_next_s  = bus.pc + {{(PC_W-1){1'b0}}, 1'b1};
          addr_s     = bus.pc + {{(PC_W-1){1'b0}}, 1'b1};
          state_s    = HOLD;
        end else begin
          state_s    = REQ;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_we_s   = 1'b1;
          pc_next_s = bus.redirect_pc;
          addr_s    = bus.redirect_pc;
          state_s   = REQ;
        end else if (bus.instr_ready) begin
          state_s   = REQ;
        end else begin
          state_s   = HOLD;
        end
      end
      FLUSH: begin
        if (bus.redirect_valid) begin
          pc_we_s   = 1'b1;
          pc_next_s = bus.redirect_pc;
          if (bus.imem_ack) begin
            addr_s  = bus.redirect_pc;
            state_s = REQ;
          end else begin
            state_s = FLUSH;
          end
        end else if (bus.imem_ack) begin
          // PC already holds the most recent redirect target
          addr_s  = bus.pc;
          state_s = REQ;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
        addr_s  = {PC_W{1'b0}};
      end
    endcase
  end

  // Output decode
  always_comb begin
    bus.pc_we       = pc_we_s & ~reset;
    bus.pc_next     = pc_next_s;
    bus.imem_req    = (state_r == REQ) || (state_r == FLUSH);
    bus.imem_addr   = addr_r;
    bus.instr_valid = (state_r == HOLD);
    bus.instr       = instr_r;
    bus.instr_pc    = instr_pc_r;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that drives the program counter register and reads instruction memory at the current PC. It issues req/ack reads to instruction memory and captures the returned word. The word is presented to decode over a valid/ready handshake. The unit drives the PC register's write-enable and next value: sequential increment after each fetch, or a redirect target from execute.

## Interface
- PC_W, 16, PC and instruction-memory address width
- INSTR_W, 16, instruction word width

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc  input  PC_W  current value from the PC register (updates the cycle after pc_we)
- pc_we  output  1  PC register write enable (combinational)
- pc_next  output  PC_W  value written to PC when pc_we=1 (combinational)
- imem_req  output  1  instruction memory read request (registered state decode)
- imem_addr  output  PC_W  read address (registered, addr_q)
- imem_ack  input  1  memory has data on imem_rdata this cycle
- imem_rdata  input  INSTR_W  read data, valid only when imem_ack=1
- instr_valid  output  1  instr/instr_pc hold a valid fetched instruction
- instr_ready  input  1  decode accepts instruction
- instr  output  INSTR_W  fetched instruction (registered)
- instr_pc  output  PC_W  address the instruction was fetched from (registered)
- redirect_valid  input  1  execute requests a PC change (branch/jump)
- redirect_pc  input  PC_W  redirect target

## Operation
- States: IDLE, REQ, HOLD, FLUSH. imem_req=1 exactly in REQ and FLUSH. instr_valid=1 exactly in HOLD.
- Reset (any state, any cycle, including mid-request):
  - state=IDLE; addr_q=0, instr=0, instr_pc=0.
  - pc_we forced 0 while reset=1.
  - An outstanding request is abandoned; the memory must tolerate a dropped req.
- IDLE: go to REQ next cycle. imem_addr=addr_q (0 after reset, matching the PC register's reset value).
- REQ, imem_ack=1, no redirect:
  - instr<=imem_rdata, instr_pc<=pc.
  - pc_we=1, pc_next=pc+1 (mod 2^PC_W; 0xFFFF wraps to 0x0000).
  - addr_q<=pc+1.
  - Go to HOLD.
- REQ, imem_ack=0: remain in REQ. imem_req and imem_addr stay stable until the ack cycle inclusive.
- HOLD:
  - instr_ready=1: transfer occurs; go to REQ (instr_valid=0 next cycle).
  - instr_ready=0: hold instr, instr_pc and valid unchanged.
- Redirect (redirect_valid=1) has priority over sequential update in every state. It forces pc_we=1 and pc_next=redirect_pc.
  - IDLE or HOLD: addr_q<=redirect_pc; go to REQ. In HOLD a simultaneous instr_ready still counts as a transfer; the held instruction is dropped either way.
  - REQ with imem_ack=1: data discarded; instr/instr_pc unchanged; addr_q<=redirect_pc; go to REQ.
  - REQ with imem_ack=0: go to FLUSH; addr_q unchanged, so the outstanding request stays stable.
  - FLUSH with imem_ack=1: data discarded; addr_q<=redirect_pc; go to REQ.
  - FLUSH with imem_ack=0: stay in FLUSH; pc updates to the newest target.
- FLUSH without redirect:
  - Hold req/addr until imem_ack. Discard the data.
  - addr_q<=pc, which holds the latest redirect target. Go to REQ. pc_we=0.
- pc_we never asserts outside the two cases above (fetch ack in REQ, redirect).

## Timing
- Zero-wait memory (ack in first REQ cycle):
  - REQ(N) → HOLD(N+1) → REQ(N+2) if ready in N+1. Peak rate is 1 instruction per 2 cycles.
  - pc reads N's value+1 from N+1.
- First request after reset release: cycle 1 (IDLE in cycle 0), addr 0x0000.
- Redirect in cycle R: PC=redirect_pc at R+1.
  - From IDLE, HOLD, or REQ with ack: the request to redirect_pc starts at R+1.
  - From REQ without ack: it starts the cycle after the abandoned request's ack.
- instr_valid drops the cycle after redirect in HOLD.
- No combinational path from imem_rdata to any output. Combinational paths exist from imem_ack, redirect_valid, redirect_pc and pc to pc_we/pc_next.

## Test plan
- Reset release, mem returns 0x1000+addr with zero wait, instr_ready=1: instr sequence 0x1000,0x1001,0x1002 with instr_pc 0,1,2; pc_we pulses once per fetch; request every 2 cycles.
- Mem ack delayed 3 cycles: imem_req/imem_addr stable for 4 cycles; exactly one pc_we; instr captured only on the ack cycle.
- instr_ready low 5 cycles in HOLD: instr/instr_pc/instr_valid constant, imem_req=0, pc unchanged, no pc_we.
- redirect_valid with redirect_pc=0x0040 during HOLD at instr_pc=5: instr_valid=0 next cycle; pc=0x0040; next imem_addr=0x0040.
- Redirect to 0x0080 in REQ with ack delayed 2 more cycles: FLUSH holds old addr; returned data discarded; then request at 0x0080. A second redirect to 0x00A0 during FLUSH yields a request at 0x00A0.
- Force pc=0xFFFF via redirect, then fetch with ack: instr_pc=0xFFFF, pc_next=0x0000. Assert reset mid-REQ: imem_req=0, instr_valid=0, imem_addr=0 next cycle.
